pipelined_multifunction_shifter: RTL and testbench

PIPELINED_MULTIFUNCTION_SHIFTER -- requirements
Module: pipelined_multifunction_shifter

---
 rtl/shifter_pkg.sv | 11 +
 rtl/shift_stage.sv | 79 +++++++
 rtl/pipelined_multifunction_shifter.sv | 68 ++++++
 tb/tb_pipelined_multifunction_shifter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared encodings for the multifunction shifter: operation modes.
package shifter_pkg;

    typedef enum logic [1:0] {
        MODE_ROT = 2'b00,
        MODE_LOG = 2'b01,
        MODE_ARI = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter stage: conditionally shifts by DIST when amt bit log2(DIST) is set, then registers.
// Latency 1 cycle; holds all state when en is low (stall), bubbles advance when en is high.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DIST     = 1,
    parameter bit RST_DATA = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_dat,
    input  logic                       in_lr,
    input  logic [1:0]                 in_mode,
    input  logic [$clog2(WIDTH)-1:0]   in_amt,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_dat,
    output logic                       out_lr,
    output logic [1:0]                 out_mode,
    output logic [$clog2(WIDTH)-1:0]   out_amt
);

    localparam int BIT = $clog2(DIST);

    logic signed [WIDTH-1:0] sdat;
    logic        [WIDTH-1:0] shifted;

    assign sdat = in_dat;

    // Arithmetic right uses the current MSB; earlier stages preserve the original sign bit.
    always_comb begin
        shifted = in_dat;
        if (in_amt[BIT]) begin
            case (mode_e'(in_mode))
                MODE_ROT: begin
                    if (in_lr) shifted = (in_dat << DIST) | (in_dat >> (WIDTH - DIST));
                    else       shifted = (in_dat >> DIST) | (in_dat << (WIDTH - DIST));
                end
                MODE_ARI: begin
                    if (in_lr) shifted = in_dat << DIST;
                    else       shifted = sdat >>> DIST;
                end
                default: begin
                    if (in_lr) shifted = in_dat << DIST;
                    else       shifted = in_dat >> DIST;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  out_valid <= 1'b0;
        else if (en) out_valid <= in_valid;
    end

    generate
        if (RST_DATA) begin : g_rst_dat
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)  out_dat <= '0;
                else if (en) out_dat <= shifted;
            end
        end else begin : g_norst_dat
            always_ff @(posedge clk) begin
                if (en) out_dat <= shifted;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (en) begin
            out_lr   <= in_lr;
            out_mode <= in_mode;
            out_amt  <= in_amt;
        end
    end

endmodule

// File: rtl/pipelined_multifunction_shifter.sv
// Pipelined rotate/logical/arithmetic shifter built from log2(WIDTH) registered stages.
// Latency AMT_W cycles; one global enable stalls every stage while the output is held unaccepted.
module pipelined_multifunction_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [AMT_W-1:0]   amt,
    input  logic               lr,
    input  logic [1:0]         mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   y
);

    logic [AMT_W:0]     stg_valid;
    logic [AMT_W:0]     stg_lr;
    logic [WIDTH-1:0]   stg_dat  [AMT_W+1];
    logic [1:0]         stg_mode [AMT_W+1];
    logic [AMT_W-1:0]   stg_amt  [AMT_W+1];
    logic               en;
    logic               unused_tail;

    assign stg_valid[0] = in_valid;
    assign stg_dat[0]   = a;
    assign stg_lr[0]    = lr;
    assign stg_mode[0]  = mode;
    assign stg_amt[0]   = amt;

    assign out_valid = stg_valid[AMT_W];
    assign y         = stg_dat[AMT_W];
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;

    // Control fields leaving the last stage have no consumer.
    assign unused_tail = ^{stg_lr[AMT_W], stg_mode[AMT_W], stg_amt[AMT_W]};

    generate
        for (genvar k = 0; k < AMT_W; k++) begin : g_stage
            shift_stage #(
                .WIDTH    (WIDTH),
                .DIST     (1 << k),
                .RST_DATA (k == AMT_W - 1)
            ) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (en),
                .in_valid  (stg_valid[k]),
                .in_dat    (stg_dat[k]),
                .in_lr     (stg_lr[k]),
                .in_mode   (stg_mode[k]),
                .in_amt    (stg_amt[k]),
                .out_valid (stg_valid[k+1]),
                .out_dat   (stg_dat[k+1]),
                .out_lr    (stg_lr[k+1]),
                .out_mode  (stg_mode[k+1]),
                .out_amt   (stg_amt[k+1])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pipelined_multifunction_shifter.sv
// Randomized and directed bench for the 16-bit pipelined shifter against an arithmetic reference model.
module tb_pipelined_multifunction_shifter;

    localparam int W  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [AW-1:0] amt;
    logic          lr;
    logic [1:0]    mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  y;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_on = 1'b0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           got_cyc[$];

    pipelined_multifunction_shifter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .amt       (amt),
        .lr        (lr),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [W-1:0] model(input logic [W-1:0] av, input logic [AW-1:0] am,
                                           input logic l, input logic [1:0] m);
        int unsigned v    = av;
        int unsigned s    = am;
        int unsigned mask = (1 << W) - 1;
        int unsigned r;
        if (m == 2'b00) begin
            if (l) r = (v << s) | (v >> (W - s));
            else   r = (v >> s) | (v << (W - s));
        end else if (l) begin
            r = v << s;
        end else if (m == 2'b10 && av[W-1]) begin
            r = (v >> s) | (mask & ~(mask >> s));
        end else begin
            r = v >> s;
        end
        return W'(r & mask);
    endfunction

    // Transfers are sampled mid-cycle, where the inputs and outputs are stable until the next edge.
    always @(negedge clk) begin
        if (rst_n && mon_on) begin
            if (in_valid && in_ready) exp_q.push_back(model(a, amt, lr, mode));
            if (out_valid && out_ready) begin
                got_q.push_back(y);
                got_cyc.push_back(cyc);
            end
        end
    end

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic drive_rand();
        a    = W'($urandom);
        amt  = AW'($urandom);
        lr   = 1'($urandom);
        mode = 2'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; amt = '0; lr = 1'b0; mode = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++;
        if (y !== 16'h0000) begin bad++; $display("FAIL reset_y got=%h want=0000", y); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic run_one(input string nm, input logic [W-1:0] av, input logic [AW-1:0] am,
                           input logic l, input logic [1:0] m, input logic [W-1:0] want);
        @(posedge clk); #1;
        a = av; amt = am; lr = l; mode = m; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_early_valid cycle=%0d got=%b want=0", nm, c, out_valid); end
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL %s_valid got=%b want=1", nm, out_valid); end
        total++;
        if (y !== want) begin bad++; $display("FAIL %s_y got=%h want=%h", nm, y, want); end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_one("rot_r1",  16'hB3CD, 4'd1, 1'b0, 2'b00, 16'hD9E6);
        run_one("rot_l1",  16'hB3CD, 4'd1, 1'b1, 2'b00, 16'h679B);
        run_one("ari_r4",  16'hB3CD, 4'd4, 1'b0, 2'b10, 16'hFB3C);
        run_one("log_r4",  16'hB3CD, 4'd4, 1'b0, 2'b01, 16'h0B3C);
        run_one("log_l4",  16'hB3CD, 4'd4, 1'b1, 2'b01, 16'h3CD0);
        run_one("rsv_r4",  16'hB3CD, 4'd4, 1'b0, 2'b11, 16'h0B3C);
        run_one("ari_l15", 16'hB3CD, 4'd15, 1'b1, 2'b10, 16'h8000);
        run_one("ari_r15", 16'hB3CD, 4'd15, 1'b0, 2'b10, 16'hFFFF);
    endtask

    task automatic test_amt_zero();
        for (int m = 0; m < 4; m++) begin
            for (int l = 0; l < 2; l++) begin
                run_one($sformatf("amt0_m%0d_lr%0d", m, l), 16'h0F0F, 4'd0, 1'(l), 2'(m), 16'h0F0F);
            end
        end
    endtask

    task automatic check_drain(input string nm);
        for (int i = 0; i < 50 && got_q.size() < exp_q.size(); i++) @(posedge clk);
        @(negedge clk);
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL %s_count got=%0d want=%0d", nm, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL %s_data idx=%0d got=%h want=%h", nm, i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        mon_on = 1'b1;
        @(posedge clk); #1 out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_rand(); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_drain("b2b");
        for (int i = 1; i < got_cyc.size(); i++) begin
            total++;
            if (got_cyc[i] !== got_cyc[0] + i) begin
                bad++; $display("FAIL b2b_consecutive idx=%0d got_cycle=%0d want_cycle=%0d", i, got_cyc[i], got_cyc[0] + i);
            end
        end
        mon_on = 1'b0;
    endtask

    task automatic test_stall();
        logic [W-1:0] hold;
        clear_q();
        mon_on = 1'b1;
        @(posedge clk); #1 out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_rand(); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        drive_rand(); out_ready = 1'b0;
        hold = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready cycle=%0d got=%b want=0", c, in_ready); end
            total++;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_out_valid cycle=%0d got=%b want=1", c, out_valid); end
            if (c == 0) hold = y;
            else begin
                total++;
                if (y !== hold) begin bad++; $display("FAIL stall_y_stable cycle=%0d got=%h want=%h", c, y, hold); end
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        check_drain("stall");
        mon_on = 1'b0;
    endtask

    task automatic test_reset_midflight();
        int seen;
        @(posedge clk); #1 out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_rand(); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL midrst_stale_outputs got=%0d want=0", seen); end
    endtask

    task automatic test_random();
        int guard = 0;
        clear_q();
        mon_on = 1'b1;
        while (exp_q.size() < 10000 && guard < 60000) begin
            @(posedge clk); #1;
            drive_rand();
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            guard++;
        end
        total++;
        if (exp_q.size() < 10000) begin bad++; $display("FAIL random_accept_budget got=%0d want=10000", exp_q.size()); end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        check_drain("random");
        mon_on = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_amt_zero();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
